// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the shared memory port arbiter.
// slave: the arbiter's view; master: requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
);
  logic [N_CH-1:0]              rd_req_valid;
  logic [N_CH-1:0][ADDR_W-1:0]  rd_req_addr;
  logic [N_CH-1:0]              rd_req_ready;
  logic [N_CH-1:0]              rd_rsp_valid;
  logic [N_CH-1:0][DATA_W-1:0]  rd_rsp_data;
  logic [N_CH-1:0]              wr_req_valid;
  logic [N_CH-1:0][ADDR_W-1:0]  wr_req_addr;
  logic [N_CH-1:0][DATA_W-1:0]  wr_req_data;
  logic [N_CH-1:0]              wr_req_ready;
  logic [N_CH-1:0]              flush;
  logic                         mem_ren;
  logic [ADDR_W-1:0]            mem_raddr;
  logic                         mem_rvalid;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_wen;
  logic [ADDR_W-1:0]            mem_waddr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [$clog2(MAX_OUT):0]     outstanding;
  logic                         proto_err;

  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
           flush, mem_rvalid, mem_rdata,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
           mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, outstanding, proto_err
  );

  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
           flush, mem_rvalid, mem_rdata,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
           mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, outstanding, proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N_CH requesters onto one memory port: independent read/write round-robin, in-order tag FIFO routes responses.
// MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority for both arbiters instead of round-robin.
module mem_port_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  mem_port_arbiter_if.slave  io_arb
);
  localparam int CH_BITS = $clog2(N_CH);
  localparam int PTR_W   = $clog2(MAX_OUT);
  localparam int CNT_W   = PTR_W + 1;

  logic [CH_BITS-1:0] r_tag_ch [MAX_OUT];
  logic [MAX_OUT-1:0] r_tag_kill;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_proto_err;
  logic               r_mem_ren;
  logic               r_mem_wen;
  logic [ADDR_W-1:0]  r_mem_raddr;
  logic [ADDR_W-1:0]  r_mem_waddr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic [CH_BITS-1:0] w_rd_start;
  logic [CH_BITS-1:0] w_wr_start;
  logic [N_CH-1:0]    w_rd_cand;
  logic               w_rd_found;
  logic               w_wr_found;
  logic [CH_BITS-1:0] w_rd_win;
  logic [CH_BITS-1:0] w_wr_win;
  logic               w_rd_ok;
  logic               w_wr_ok;
  logic [N_CH-1:0]    w_rd_rdy;
  logic [N_CH-1:0]    w_wr_rdy;
  logic [N_CH-1:0]    w_rsp_vld;
  logic               w_pop;
  logic               w_head_live;

  // Returns {found, channel}; scanning downward lets the lowest offset from start win.
  function automatic logic [CH_BITS:0] pick(input logic [N_CH-1:0] req,
                                            input logic [CH_BITS-1:0] start);
    logic [CH_BITS:0] res;
    int               idx;
    res = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      idx = (int'(start) + off) % N_CH;
      if (req[idx]) res = {1'b1, CH_BITS'(idx)};
    end
    return res;
  endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_rd_start = '0;
  assign w_wr_start = '0;
`else
  logic [CH_BITS-1:0] r_rd_ptr;
  logic [CH_BITS-1:0] r_wr_ptr;
  assign w_rd_start = r_rd_ptr;
  assign w_wr_start = r_wr_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_rd_ok) r_rd_ptr <= (w_rd_win == CH_BITS'(N_CH - 1)) ? '0 : w_rd_win + CH_BITS'(1);
      if (w_wr_ok) r_wr_ptr <= (w_wr_win == CH_BITS'(N_CH - 1)) ? '0 : w_wr_win + CH_BITS'(1);
    end
  end
`endif

  // A flushing channel is masked before arbitration so another requester may still win.
  assign w_rd_cand = io_arb.rd_req_valid & ~io_arb.flush;

  always_comb begin
    {w_rd_found, w_rd_win} = pick(w_rd_cand, w_rd_start);
    {w_wr_found, w_wr_win} = pick(io_arb.wr_req_valid, w_wr_start);
    w_rd_ok = i_rst && w_rd_found && (r_count < CNT_W'(MAX_OUT));
    w_wr_ok = i_rst && w_wr_found;
    w_rd_rdy = '0;
    w_wr_rdy = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rd_rdy[i] = w_rd_ok && (w_rd_win == CH_BITS'(i));
      w_wr_rdy[i] = w_wr_ok && (w_wr_win == CH_BITS'(i));
    end
  end

  assign w_pop       = i_rst && io_arb.mem_rvalid && (r_count != '0);
  assign w_head_live = !r_tag_kill[r_head] && !io_arb.flush[r_tag_ch[r_head]];

  always_comb begin
    w_rsp_vld = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rsp_vld[i] = w_pop && w_head_live && (r_tag_ch[r_head] == CH_BITS'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tag_kill  <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_raddr <= '0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_ren <= w_rd_ok;
      r_mem_wen <= w_wr_ok;
      if (w_rd_ok) r_mem_raddr <= io_arb.rd_req_addr[w_rd_win];
      if (w_wr_ok) begin
        r_mem_waddr <= io_arb.wr_req_addr[w_wr_win];
        r_mem_wdata <= io_arb.wr_req_data[w_wr_win];
      end
      // Stale slots may get killed too; a push always rewrites kill.
      for (int k = 0; k < MAX_OUT; k++) begin
        if (io_arb.flush[r_tag_ch[k]]) r_tag_kill[k] <= 1'b1;
      end
      if (w_rd_ok) begin
        r_tag_ch[r_tail]   <= w_rd_win;
        r_tag_kill[r_tail] <= 1'b0;
        r_tail             <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_rd_ok) - CNT_W'(w_pop);
      if (io_arb.mem_rvalid && (r_count == '0)) r_proto_err <= 1'b1;
    end
  end

  assign io_arb.rd_req_ready = w_rd_rdy;
  assign io_arb.wr_req_ready = w_wr_rdy;
  assign io_arb.rd_rsp_valid = w_rsp_vld;
  assign io_arb.rd_rsp_data  = {N_CH{io_arb.mem_rdata}};
  assign io_arb.mem_ren      = r_mem_ren;
  assign io_arb.mem_raddr    = r_mem_raddr;
  assign io_arb.mem_wen      = r_mem_wen;
  assign io_arb.mem_waddr    = r_mem_waddr;
  assign io_arb.mem_wdata    = r_mem_wdata;
  assign io_arb.outstanding  = r_count;
  assign io_arb.proto_err    = r_proto_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: read tags queued on accept, matched against routed responses.
module tb_mem_port_arbiter;
  localparam int N_CH = 2, ADDR_W = 64, DATA_W = 64, MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) bus ();

  mem_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_arb (bus)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          q_ch[$];
  bit          q_kill[$];
  int          gnt_log[$];
  bit          pend_ren, pend_wen;
  logic [63:0] pend_raddr, pend_waddr, pend_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 16; n++) begin
      bus.mem_rvalid = (q_ch.size() > 0);
      bus.mem_rdata  = {$urandom, $urandom};
      cyc();
    end
    bus.mem_rvalid = 1'b0;
  endtask

  // Scoreboard monitor: expected state before this cycle's edge, then updates for the edge.
  always @(negedge clk) begin : mon
    int          c;
    logic [63:0] ev;
    if (!rst) begin
      chk("rst_rdy", {bus.wr_req_ready, bus.rd_req_ready}, 64'd0);
      q_ch.delete();
      q_kill.delete();
      pend_ren = 1'b0;
      pend_wen = 1'b0;
    end else begin
      chk("outst", bus.outstanding, q_ch.size());
      chk("ren", bus.mem_ren, pend_ren);
      if (pend_ren) chk("raddr", bus.mem_raddr, pend_raddr);
      chk("wen", bus.mem_wen, pend_wen);
      if (pend_wen) begin
        chk("waddr", bus.mem_waddr, pend_waddr);
        chk("wdata", bus.mem_wdata, pend_wdata);
      end
      if (bus.flush != '0) chk("flush_rdy", bus.rd_req_ready & bus.flush, 64'd0);
      if (bus.mem_rvalid && q_ch.size() > 0) begin
        c  = q_ch.pop_front();
        ev = (q_kill.pop_front() || bus.flush[c]) ? 64'd0 : (64'd1 << c);
        chk("rsp_vld", bus.rd_rsp_valid, ev);
        if (ev != 0) chk("rsp_dat", bus.rd_rsp_data[c], bus.mem_rdata);
      end else begin
        chk("rsp_idle", bus.rd_rsp_valid, 64'd0);
      end
      for (int k = 0; k < q_ch.size(); k++) begin
        if (bus.flush[q_ch[k]]) q_kill[k] = 1'b1;
      end
      pend_ren = 1'b0;
      pend_wen = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (bus.rd_req_valid[i] && bus.rd_req_ready[i]) begin
          q_ch.push_back(i);
          q_kill.push_back(1'b0);
          gnt_log.push_back(i);
          pend_ren   = 1'b1;
          pend_raddr = bus.rd_req_addr[i];
        end
        if (bus.wr_req_valid[i] && bus.wr_req_ready[i]) begin
          pend_wen   = 1'b1;
          pend_waddr = bus.wr_req_addr[i];
          pend_wdata = bus.wr_req_data[i];
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          chs[3];
    logic [63:0] dat[3];
    bus.rd_req_valid = '0;
    bus.rd_req_addr  = '0;
    bus.wr_req_valid = '0;
    bus.wr_req_addr  = '0;
    bus.wr_req_data  = '0;
    bus.flush        = '0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;

    // Reset: requests held high must see no ready
    bus.rd_req_valid = 2'b11;
    bus.wr_req_valid = 2'b11;
    repeat (3) cyc();
    bus.rd_req_valid = '0;
    bus.wr_req_valid = '0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outst", bus.outstanding, 0);
    chk("rst_ren", bus.mem_ren, 0);
    chk("rst_wen", bus.mem_wen, 0);
    chk("rst_raddr", bus.mem_raddr, 0);
    chk("rst_waddr", bus.mem_waddr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_perr", bus.proto_err, 0);

    // Read latency
    cyc();
    bus.rd_req_valid   = 2'b01;
    bus.rd_req_addr[0] = 64'h1000;
    @(negedge clk);
    chk("lat_rdy", bus.rd_req_ready, 2'b01);
    cyc();
    bus.rd_req_valid = '0;
    @(negedge clk);
    chk("lat_ren", bus.mem_ren, 1);
    chk("lat_raddr", bus.mem_raddr, 64'h1000);
    chk("lat_out1", bus.outstanding, 1);
    cyc();
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hAA;
    @(negedge clk);
    chk("lat_rsp", bus.rd_rsp_valid, 2'b01);
    chk("lat_dat", bus.rd_rsp_data[0], 64'hAA);
    cyc();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("lat_out0", bus.outstanding, 0);

    // Fairness: both channels request continuously
    cyc();
    gnt_log.delete();
    bus.rd_req_valid   = 2'b11;
    bus.rd_req_addr[0] = 64'h100;
    bus.rd_req_addr[1] = 64'h200;
    for (int n = 0; n < 8; n++) begin
      bus.mem_rvalid = (q_ch.size() > 0);
      bus.mem_rdata  = {$urandom, $urandom};
      cyc();
    end
    bus.rd_req_valid = '0;
    drain();
    chk("rr_cnt", gnt_log.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      if (gnt_log.size() > k) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("rr_gnt", gnt_log[k], 0);
`else
        chk("rr_gnt", gnt_log[k], (k + 1) % 2);
`endif
      end
    end

    // Full tag FIFO
    bus.rd_req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      bus.rd_req_addr[0] = 64'h3000 + 64'(k * 8);
      @(negedge clk);
      chk("full_acc", bus.rd_req_ready[0], 1);
      cyc();
    end
    bus.rd_req_addr[0] = 64'h3100;
    @(negedge clk);
    chk("full_blk", bus.rd_req_ready[0], 0);
    chk("full_out", bus.outstanding, 4);
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h5A;
    @(negedge clk);
    chk("full_pop_blk", bus.rd_req_ready[0], 0);
    cyc();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("full_5th", bus.rd_req_ready[0], 1);
    cyc();
    bus.rd_req_valid = '0;
    drain();

    // In-order routing ch1, ch0, ch1
    chs = '{1, 0, 1};
    dat = '{64'h11, 64'h22, 64'h33};
    for (int k = 0; k < 3; k++) begin
      bus.rd_req_valid         = '0;
      bus.rd_req_valid[chs[k]] = 1'b1;
      bus.rd_req_addr[chs[k]]  = 64'h5000 + 64'(k);
      @(negedge clk);
      chk("ord_rdy", bus.rd_req_ready[chs[k]], 1);
      cyc();
    end
    bus.rd_req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = dat[k];
      @(negedge clk);
      chk("ord_vld", bus.rd_rsp_valid, 64'd1 << chs[k]);
      chk("ord_dat", bus.rd_rsp_data[chs[k]], dat[k]);
      cyc();
    end
    bus.mem_rvalid = 1'b0;

    // Flush ch0 with ch0 and ch1 reads outstanding
    bus.rd_req_valid = 2'b01;
    cyc();
    bus.rd_req_valid = 2'b10;
    cyc();
    bus.rd_req_valid = 2'b01;
    bus.flush        = 2'b01;
    @(negedge clk);
    chk("fl_rdy", bus.rd_req_ready, 0);
    cyc();
    bus.rd_req_valid = '0;
    bus.flush        = '0;
    bus.mem_rvalid   = 1'b1;
    bus.mem_rdata    = 64'h66;
    @(negedge clk);
    chk("fl_rsp0", bus.rd_rsp_valid, 0);
    cyc();
    bus.mem_rdata = 64'h77;
    @(negedge clk);
    chk("fl_rsp1", bus.rd_rsp_valid, 2'b10);
    chk("fl_dat1", bus.rd_rsp_data[1], 64'h77);
    cyc();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("fl_out0", bus.outstanding, 0);

    // Reset with two reads in flight, then an orphan response
    cyc();
    bus.rd_req_valid = 2'b01;
    cyc();
    bus.rd_req_valid = 2'b10;
    cyc();
    bus.rd_req_valid = '0;
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_out0", bus.outstanding, 0);
    chk("mr_perr0", bus.proto_err, 0);
    cyc();
    bus.mem_rvalid = 1'b1;
    cyc();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("mr_perr1", bus.proto_err, 1);

    // Concurrent read and write
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.rd_req_valid   = 2'b01;
    bus.rd_req_addr[0] = 64'h4000;
    bus.wr_req_valid   = 2'b10;
    bus.wr_req_addr[1] = 64'h2000;
    bus.wr_req_data[1] = 64'h55;
    @(negedge clk);
    chk("rw_rrdy", bus.rd_req_ready, 2'b01);
    chk("rw_wrdy", bus.wr_req_ready, 2'b10);
    cyc();
    bus.rd_req_valid = '0;
    bus.wr_req_valid = '0;
    @(negedge clk);
    chk("rw_ren", bus.mem_ren, 1);
    chk("rw_wen", bus.mem_wen, 1);
    chk("rw_waddr", bus.mem_waddr, 64'h2000);
    chk("rw_wdata", bus.mem_wdata, 64'h55);
    cyc();
    drain();

    // Write arbitration with both channels requesting
    bus.wr_req_valid   = 2'b11;
    bus.wr_req_addr[0] = 64'h6000;
    bus.wr_req_data[0] = 64'hA0;
    bus.wr_req_addr[1] = 64'h6100;
    bus.wr_req_data[1] = 64'hB1;
    @(negedge clk);
    chk("wr_gnt0", bus.wr_req_ready, 2'b01);
    cyc();
    @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("wr_gnt1", bus.wr_req_ready, 2'b01);
`else
    chk("wr_gnt1", bus.wr_req_ready, 2'b10);
`endif
    cyc();
    bus.wr_req_valid = '0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Merges N_CH requester channels (fetch, LSU, future prefetcher) onto the single shared memory read/write port.
- Replaces the separate instruction and data memory ports at the cpu top level.
- Arbitrates reads and writes independently, round-robin by default.
- Tracks outstanding reads in an in-order tag FIFO and routes each returning mem_rdata to its requester.
- Supports per-channel flush, which silently drops that channel's in-flight read responses (used on ROB flush).

Parameters:
- N_CH, 2, number of requester channels (>=2); CH_BITS = $clog2(N_CH).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MAX_OUT, 4, maximum outstanding reads (tag FIFO depth, power of two).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- rd_req_valid  input  [N_CH]  per-channel read request
- rd_req_addr  input  [N_CH][ADDR_W]  read address
- rd_req_ready  output  [N_CH]  read request accepted this cycle
- rd_rsp_valid  output  [N_CH]  read data valid for channel
- rd_rsp_data  output  [N_CH][DATA_W]  read data (same value on all channels)
- wr_req_valid  input  [N_CH]  per-channel write request
- wr_req_addr  input  [N_CH][ADDR_W]  write address
- wr_req_data  input  [N_CH][DATA_W]  write data
- wr_req_ready  output  [N_CH]  write accepted this cycle
- flush  input  [N_CH]  drop outstanding reads of that channel
- mem_ren  output  1  memory read enable
- mem_raddr  output  ADDR_W  memory read address
- mem_rvalid  input  1  memory read data valid (in request order)
- mem_rdata  input  DATA_W  memory read data
- mem_wen  output  1  memory write enable
- mem_waddr  output  ADDR_W  memory write address
- mem_wdata  output  DATA_W  memory write data
- outstanding  output  $clog2(MAX_OUT)+1  current tag FIFO occupancy
- proto_err  output  1  sticky: mem_rvalid arrived with tag FIFO empty

Behaviour:
- Reset (rst==0 at posedge):
  - mem_ren=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
  - Tag FIFO empty, outstanding=0, proto_err=0.
  - Both round-robin pointers=0.
  - rd_req_ready and wr_req_ready are 0 during reset.
  - A reset mid-operation discards all in-flight tags; a later mem_rvalid with an empty FIFO sets proto_err.
- Read arbitration (combinational grant):
  - Scan channels from rd_ptr upward, with wrap.
  - The first channel with rd_req_valid wins, provided outstanding < MAX_OUT.
  - rd_req_ready[i]=1 only for the winner. Handshake = valid & ready.
  - On handshake:
    - rd_ptr <= (winner+1) mod N_CH.
    - Push {ch=winner, kill=0} to the FIFO.
    - Register mem_ren=1 and mem_raddr=addr the next cycle (1-cycle latency).
  - mem_ren is a single-cycle pulse per accepted read; at most one read is issued per cycle.
- Full boundary:
  - Ready uses the registered count, so no push occurs when outstanding==MAX_OUT, even if a pop happens in the same cycle.
- Response path (combinational):
  - When mem_rvalid=1, pop the FIFO head.
  - If head.kill==0: rd_rsp_valid[head.ch]=1 with rd_rsp_data=mem_rdata.
  - If head.kill==1: no rsp_valid is raised.
  - All other rd_rsp_valid bits are 0.
- Simultaneous push and pop: occupancy is unchanged; pointer wrap is mod MAX_OUT.
- Flush:
  - flush[i]=1 sets kill on every valid FIFO entry with ch==i (applied at posedge).
  - In the same cycle, rd_req_ready[i] is forced to 0.
  - If the popped head belongs to i in the flush cycle, its rd_rsp_valid is suppressed.
  - A read accepted in a later cycle is unaffected.
- Write arbitration:
  - Uses an independent wr_ptr with the same round-robin rule.
  - No capacity limit; wr_req_ready goes to the winner.
  - On handshake, register mem_wen=1 with the winner's addr/data next cycle, as a single-cycle pulse.
  - flush has no effect on writes.
  - A read and a write may both be issued in the same cycle.
- outstanding is registered FIFO occupancy, including killed entries.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN
  - Defined: both read and write arbiters use fixed priority, where the lowest channel index wins. rd_ptr and wr_ptr are removed.
  - Undefined: round-robin as described.
  - All other behaviour is identical.

Test Plan:
- Read latency:
  - Stimulus: N_CH=2; ch0 read 0x1000 at cycle 5; memory returns 0xAA at cycle 8.
  - Required: rd_req_ready[0]=1 at cycle 5; mem_ren=1 with mem_raddr=0x1000 at cycle 6; rd_rsp_valid[0]=1 with data 0xAA at cycle 8; outstanding goes 0→1→0.
- Round-robin fairness:
  - Stimulus: ch0 and ch1 hold reads continuously, with responses returned promptly.
  - Required: grants alternate 0,1,0,1. With MEM_ARB_FIXED_PRIO_EN defined, every grant goes to ch0.
- Full FIFO:
  - Stimulus: MAX_OUT=4; issue 4 reads with no mem_rvalid.
  - Required: ready=0 on the 5th request; after one mem_rvalid, the next cycle accepts the 5th read.
- In-order routing:
  - Stimulus: reads accepted in order ch1, ch0, ch1; responses 0x11, 0x22, 0x33.
  - Required: ch1 gets 0x11, ch0 gets 0x22, ch1 gets 0x33.
- Flush:
  - Stimulus: ch0 and ch1 reads outstanding (order ch0, ch1); pulse flush[0]; then two mem_rvalid.
  - Required: no rd_rsp_valid[0]; rd_rsp_valid[1]=1 on the second response; outstanding returns to 0.
- Reset mid-flight and concurrent read/write:
  - Stimulus: rst=0 with 2 reads outstanding; after release, one mem_rvalid.
  - Required: proto_err=1. Separately, a ch0 read and a ch1 write 0x2000/0x55 accepted in the same cycle yield mem_ren and mem_wen both asserted on the next cycle.
